mfp_ahb_uart_tx: RTL

Memory-mapped UART transmitter on the AHB-Lite bus, complementing the serial-load UART receive path of the MIPS system. The core writes bytes into a 16-entry transmit FIFO over AHB-Lite. A baud-rate generator and frame state machine serialise the bytes as 8N1 frames on `UART_TX`. The block is a zero-wait-state AHB-Lite responder, selected by the system AHB decoder via `HSEL`.

---
 rtl/mfp_ahb_uart_tx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite zero-wait-state UART transmitter: 16-entry byte FIFO feeding an
// 8N1 serialiser with a programmable baud divider.
module mfp_ahb_uart_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        SI_Reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        UART_TX,
  output logic        TX_Idle,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  // o_dbg_state encoding: 0=IDLE, 1=START, 2=DATA, 3=STOP
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  logic          r_dp_valid;
  logic          r_dp_write;
  logic [1:0]    r_dp_addr;
  logic          r_en;
  logic          r_ovf;
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic [AW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_wr_txdata;
  logic          w_wr_ctrl;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_zero;
  logic [7:0]    w_head;
  logic [31:0]   w_status;
  logic          w_unused;

  // Handshake: an address phase is taken when HSEL & HTRANS[1] & HREADY; its
  // data phase is always the next cycle since this responder never stalls.
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 2'd0;
    end else begin
      r_dp_valid <= HSEL & HTRANS[1] & HREADY;
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[3:2];
    end
  end

  assign w_count     = r_wptr - r_rptr;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_wr_txdata = r_dp_valid & r_dp_write & (r_dp_addr == 2'd0);
  assign w_wr_ctrl   = r_dp_valid & r_dp_write & (r_dp_addr == 2'd2);
  assign w_push      = w_wr_txdata & ~w_full;
  assign w_baud_zero = (r_baud == '0);
  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign w_pop       = r_en & ~w_empty &
                       ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_zero));

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_en  <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en <= HWDATA[0];
        if (HWDATA[1]) r_ovf <= 1'b0;
      end
      // Full is judged before any same-cycle pop, so this push is lost.
      if (w_wr_txdata & w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= BAUD_LAST;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_zero) begin
            r_state   <= S_DATA;
            r_baud    <= BAUD_LAST;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_zero) begin
            r_baud <= BAUD_LAST;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_zero) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_baud  <= BAUD_LAST;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[0]            = w_full;
    w_status[1]            = w_empty;
    w_status[2]            = (r_state != S_IDLE);
    w_status[3]            = r_ovf;
    w_status[4 +: AW+1]    = w_count;
  end

  always_comb begin
    HRDATA = '0;
    if (r_dp_valid & ~r_dp_write) begin
      case (r_dp_addr)
        2'd1:    HRDATA = w_status;
        2'd2:    HRDATA = {31'd0, r_en};
        default: HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign UART_TX     = r_tx;
  assign TX_Idle     = w_empty & (r_state == S_IDLE);
  assign o_dbg_state = r_state;
  assign w_unused    = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:8]};

endmodule
